// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on input and output.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (MUL/MULHU).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             v,
    output logic             z,
    output logic             s,
    output logic             c,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t           r_state;
    logic [3:0]       r_sel;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_o;
    logic             r_v;
    logic             r_z;
    logic             r_s;
    logic             r_c;
    logic             r_err;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [SHW:0]       r_cnt;
    logic [WIDTH:0]     w_acc_hi_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    // One shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign w_acc_hi_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                        + (r_acc[0] ? {1'b0, r_x} : {(WIDTH+1){1'b0}});
    assign w_acc_next   = {w_acc_hi_sum, r_acc[WIDTH-1:1]};
`endif

    // Top bit of w_diff is the borrow out of x - y.
    assign w_sum    = {1'b0, r_x} + {1'b0, r_y};
    assign w_diff   = {1'b0, r_x} - {1'b0, r_y};
    assign w_shamt  = r_y[SHW-1:0];
    assign w_lt_s   = $signed(r_x) < $signed(r_y);
    assign w_lt_u   = r_x < r_y;
    assign in_ready = (r_state == ST_IDLE);

    // Result and carry/overflow selection from the captured operands.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (r_sel)
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_x[MSB] == r_y[MSB]) && (w_sum[MSB] != r_x[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (r_x[MSB] != r_y[MSB]) && (w_diff[MSB] != r_x[MSB]);
            end
            OP_AND:  w_res = r_x & r_y;
            OP_OR:   w_res = r_x | r_y;
            OP_XOR:  w_res = r_x ^ r_y;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
            OP_SLL:  w_res = r_x << w_shamt;
            OP_SRL:  w_res = r_x >> w_shamt;
            OP_SRA:  w_res = $unsigned($signed(r_x) >>> w_shamt);
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:   w_res = r_acc[WIDTH-1:0];
            OP_MULHU: w_res = r_acc[2*WIDTH-1:WIDTH];
`endif
            default: w_err = 1'b1;
        endcase
    end

    // Control FSM with capture, multiplier iteration and registered results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= 4'd0;
            r_x         <= {WIDTH{1'b0}};
            r_y         <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_o         <= {WIDTH{1'b0}};
            r_v         <= 1'b0;
            r_z         <= 1'b0;
            r_s         <= 1'b0;
            r_c         <= 1'b0;
            r_err       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_acc       <= {(2*WIDTH){1'b0}};
            r_cnt       <= {(SHW+1){1'b0}};
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sel <= sel;
                        r_x   <= x;
                        r_y   <= y;
`ifdef ALU_SEQ_MUL_EN
                        if ((sel == OP_MUL) || (sel == OP_MULHU)) begin
                            r_acc   <= {{WIDTH{1'b0}}, y};
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                        end
`else
                        r_state <= ST_DONE;
`endif
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    // First DONE cycle registers the result; later cycles wait for the consumer.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_o         <= w_res;
                        r_v         <= w_v;
                        r_c         <= w_c;
                        r_z         <= (w_res == {WIDTH{1'b0}});
                        r_s         <= w_res[MSB];
                        r_err       <= w_err;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign o         = r_o;
    assign v         = r_v;
    assign z         = r_z;
    assign s         = r_s;
    assign c         = r_c;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed cases plus randomized ops
// against an arithmetic reference model; follows ALU_SEQ_MUL_EN like the design.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] o;
        logic        v;
        logic        z;
        logic        s;
        logic        c;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] o;
    logic        v, z, s, c, err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .v(v), .z(z), .s(s), .c(c), .err(err)
    );

    always #5 clk = ~clk;

    function automatic res_t observed();
        res_t r;
        r = {o, v, z, s, c, err};
        return r;
    endfunction

    function automatic res_t mk(input logic [31:0] ro, input logic rv, input logic rz,
                                input logic rs, input logic rc, input logic re);
        res_t r;
        r = {ro, rv, rz, rs, rc, re};
        return r;
    endfunction

    function automatic bit is_mul(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
        return (op == 4'd10) || (op == 4'd11);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain 64-bit arithmetic on the operand values.
    function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint          sa, sb, sr;
        longint unsigned ua, ub, ur;
        int              sh;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(b % 32'd32);
        case (op)
            4'd0: begin
                ur = ua + ub; r.o = ur[31:0]; r.c = (ur > 64'd4294967295);
                sr = sa + sb; r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                ur = ua - ub; r.o = ur[31:0]; r.c = (ua >= ub);
                sr = sa - sb; r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: r.o = a & b;
            4'd3: r.o = a | b;
            4'd4: r.o = a ^ b;
            4'd5: r.o = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: r.o = (ua < ub) ? 32'd1 : 32'd0;
            4'd7: r.o = a << sh;
            4'd8: r.o = a >> sh;
            4'd9: begin sr = sa >>> sh; r.o = sr[31:0]; end
`ifdef ALU_SEQ_MUL_EN
            4'd10: begin ur = ua * ub; r.o = ur[31:0]; end
            4'd11: begin ur = ua * ub; r.o = ur[63:32]; end
`endif
            default: r.err = 1'b1;
        endcase
        r.z = (r.o == 32'd0);
        r.s = r.o[31];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency, check result, consume it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input res_t exp);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        sel = op; x = a; y = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        x = $urandom; y = $urandom; sel = 4'($urandom);
        out_ready = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 100);
        check({tag, " latency"}, 64'(lat), is_mul(op) ? 64'd33 : 64'd1);
        check({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " result"}, 64'(observed()), 64'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, " consumed"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int   lat;
        int   seen;
        res_t held;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        // Reset held two cycles with in_valid asserted.
        rst_n = 1'b0; in_valid = 1'b1; sel = 4'd0; x = 32'd1; y = 32'd1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst outputs", 64'(observed()), 64'd0);
        in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst no accept", 64'(out_valid), 64'd0);

        run_op("add carry", 4'd0, 32'hFFFF_FFFF, 32'd1, mk(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        run_op("add ovf",   4'd0, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        run_op("sub",       4'd1, 32'd3, 32'd5, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        run_op("sra",       4'd9, 32'h8000_0000, 32'h21, mk(32'hC000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        run_op("slt",       4'd5, 32'hFFFF_FFFF, 32'd1, mk(32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        run_op("sltu",      4'd6, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef ALU_SEQ_MUL_EN
        run_op("mul",   4'd10, 32'h1_0000, 32'h1_0000, mk(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        run_op("mulhu", 4'd11, 32'h1_0000, 32'h1_0000, mk(32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        run_op("mul off",   4'd10, 32'h1_0000, 32'h1_0000, mk(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        run_op("mulhu off", 4'd11, 32'h1_0000, 32'h1_0000, mk(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
`endif
        run_op("illegal 13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));

        // Backpressure: result held 5 cycles while a new offer is pending.
        @(negedge clk);
        sel = 4'd4; x = 32'hF0F0_1234; y = 32'h0FF0_4321; in_valid = 1'b1;
        @(posedge clk);
        #1 sel = 4'd1; x = 32'd10; y = 32'd20;
        @(posedge clk);
        @(negedge clk);
        check("bp first valid", 64'(out_valid), 64'd1);
        held = model(4'd4, 32'hF0F0_1234, 32'h0FF0_4321);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp held valid", 64'(out_valid), 64'd1);
            check("bp held result", 64'(observed()), 64'(held));
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp released in_ready", 64'(in_ready), 64'd1);
        check("bp released valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp next accepted", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp next valid", 64'(out_valid), 64'd1);
        check("bp next result", 64'(observed()), 64'(model(4'd1, 32'd10, 32'd20)));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the middle of an operation discards it.
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        sel = 4'd10; x = 32'hDEAD_BEEF; y = 32'h1234_5677; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
`else
        sel = 4'd0; x = 32'hDEAD_BEEF; y = 32'h1234_5677; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid rst valid", 64'(out_valid), 64'd0);
        check("mid rst in_ready", 64'(in_ready), 64'd1);
        check("mid rst outputs", 64'(observed()), 64'd0);
        out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid rst no result", 64'(seen), 64'd0);
        out_ready = 1'b0;

        // Randomized ops with corner-biased operands.
        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            if (k % 7 == 3) rb = ra;
            run_op($sformatf("rand%0d op%0d", k, rop), rop, ra, rb, model(rop, ra, rb));
        end

        lat = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
